// File: rtl/ex_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the EX-stage hazard controller.
// master = pipeline side (drives stage info), slave = hazard controller.
interface ex_hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic [4:0]  ex_rd;
    logic        ex_rf_enable;
    logic        ex_load_instr;
    logic        ex_branch_taken;
    logic [4:0]  mem_rd;
    logic        mem_rf_enable;
    logic [4:0]  wb_rd;
    logic        wb_rf_enable;
    logic        pc_ld;
    logic        ifid_ld;
    logic        ifid_flush;
    logic        ex_nop;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;
    logic [1:0]  state;
    logic [15:0] stall_count;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt,
        output ex_rd, ex_rf_enable, ex_load_instr, ex_branch_taken,
        output mem_rd, mem_rf_enable, wb_rd, wb_rf_enable,
        input  pc_ld, ifid_ld, ifid_flush, ex_nop, fwd_a, fwd_b, state, stall_count
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt,
        input  ex_rd, ex_rf_enable, ex_load_instr, ex_branch_taken,
        input  mem_rd, mem_rf_enable, wb_rd, wb_rf_enable,
        output pc_ld, ifid_ld, ifid_flush, ex_nop, fwd_a, fwd_b, state, stall_count
    );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard controller: load-use stalls, taken-branch flushes, operand
// forwarding selects and a saturating stall-cycle counter.
module ex_hazard_ctrl #(
    parameter int LOAD_BUBBLES = 1,
    parameter int BR_BUBBLES   = 1
) (
    input  logic             clk,
    input  logic             reset,
    ex_hazard_ctrl_if.slave  hz
);

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_STALL = 2'b01;
    localparam logic [1:0] ST_FLUSH = 2'b10;

    logic [1:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic        lu;
    logic        pc_ld, ifid_ld, ifid_flush, ex_nop;

    // A load still in EX cannot forward; its result only exists after MEM.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       use_src,
        input logic [4:0] ex_rd,
        input logic       ex_we,
        input logic       ex_load,
        input logic [4:0] mem_rd,
        input logic       mem_we,
        input logic [4:0] wb_rd,
        input logic       wb_we
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (use_src && src != 5'd0) begin
            if (ex_we && !ex_load && ex_rd == src)
                sel = 2'b01;
            else if (mem_we && mem_rd == src)
                sel = 2'b10;
            else if (wb_we && wb_rd == src)
                sel = 2'b11;
        end
        return sel;
    endfunction

    always_comb begin
        lu = hz.ex_load_instr && hz.ex_rf_enable && (hz.ex_rd != 5'd0) &&
             ((hz.id_use_rs && hz.id_rs == hz.ex_rd) ||
              (hz.id_use_rt && hz.id_rt == hz.ex_rd));
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_ld      = 1'b1;
        ifid_ld    = 1'b1;
        ifid_flush = 1'b0;
        ex_nop     = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (hz.ex_branch_taken) begin
                    ifid_flush = 1'b1;
                    ex_nop     = 1'b1;
                    cnt_d      = 2'(BR_BUBBLES - 1);
                    state_d    = (BR_BUBBLES > 1) ? ST_FLUSH : ST_RUN;
                end else if (lu) begin
                    pc_ld   = 1'b0;
                    ifid_ld = 1'b0;
                    ex_nop  = 1'b1;
                    cnt_d   = 2'(LOAD_BUBBLES - 1);
                    state_d = (LOAD_BUBBLES > 1) ? ST_STALL : ST_RUN;
                end
            end
            ST_STALL: begin
                pc_ld   = 1'b0;
                ifid_ld = 1'b0;
                ex_nop  = 1'b1;
                cnt_d   = cnt_q - 2'd1;
                if (cnt_q <= 2'd1) begin
                    cnt_d   = 2'd0;
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                ifid_flush = 1'b1;
                ex_nop     = 1'b1;
                cnt_d      = cnt_q - 2'd1;
                if (cnt_q <= 2'd1) begin
                    cnt_d   = 2'd0;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 2'd0;
            end
        endcase
        // While reset is held the pipeline must run freely, whatever the inputs say.
        if (!reset) begin
            pc_ld      = 1'b1;
            ifid_ld    = 1'b1;
            ifid_flush = 1'b0;
            ex_nop     = 1'b0;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (!pc_ld && stall_count_q != 16'hFFFF)
            stall_count_d = stall_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            cnt_q         <= 2'd0;
            stall_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign hz.pc_ld       = pc_ld;
    assign hz.ifid_ld     = ifid_ld;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.ex_nop      = ex_nop;
    assign hz.state       = state_q;
    assign hz.stall_count = stall_count_q;
    assign hz.fwd_a = fwd_sel(hz.id_rs, hz.id_use_rs, hz.ex_rd, hz.ex_rf_enable,
                              hz.ex_load_instr, hz.mem_rd, hz.mem_rf_enable,
                              hz.wb_rd, hz.wb_rf_enable);
    assign hz.fwd_b = fwd_sel(hz.id_rt, hz.id_use_rt, hz.ex_rd, hz.ex_rf_enable,
                              hz.ex_load_instr, hz.mem_rd, hz.mem_rf_enable,
                              hz.wb_rd, hz.wb_rf_enable);

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: dut_a uses 1/1 bubbles, dut_b 3 load / 2 branch bubbles.
module tb_ex_hazard_ctrl;
  logic clk;
  logic reset;

  logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic id_use_rs, id_use_rt, ex_rf_enable, ex_load_instr, ex_branch_taken;
  logic mem_rf_enable, wb_rf_enable;

  int n_pass;
  int n_total;

  ex_hazard_ctrl_if ia();
  ex_hazard_ctrl_if ib();

  assign ia.id_rs = id_rs;               assign ib.id_rs = id_rs;
  assign ia.id_rt = id_rt;               assign ib.id_rt = id_rt;
  assign ia.id_use_rs = id_use_rs;       assign ib.id_use_rs = id_use_rs;
  assign ia.id_use_rt = id_use_rt;       assign ib.id_use_rt = id_use_rt;
  assign ia.ex_rd = ex_rd;               assign ib.ex_rd = ex_rd;
  assign ia.ex_rf_enable = ex_rf_enable; assign ib.ex_rf_enable = ex_rf_enable;
  assign ia.ex_load_instr = ex_load_instr;     assign ib.ex_load_instr = ex_load_instr;
  assign ia.ex_branch_taken = ex_branch_taken; assign ib.ex_branch_taken = ex_branch_taken;
  assign ia.mem_rd = mem_rd;             assign ib.mem_rd = mem_rd;
  assign ia.mem_rf_enable = mem_rf_enable;     assign ib.mem_rf_enable = mem_rf_enable;
  assign ia.wb_rd = wb_rd;               assign ib.wb_rd = wb_rd;
  assign ia.wb_rf_enable = wb_rf_enable; assign ib.wb_rf_enable = wb_rf_enable;

  ex_hazard_ctrl #(.LOAD_BUBBLES(1), .BR_BUBBLES(1)) dut_a (
    .clk(clk), .reset(reset), .hz(ia)
  );
  ex_hazard_ctrl #(.LOAD_BUBBLES(3), .BR_BUBBLES(2)) dut_b (
    .clk(clk), .reset(reset), .hz(ib)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "time budget expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic clear_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    ex_rd = 5'd0; ex_rf_enable = 1'b0; ex_load_instr = 1'b0; ex_branch_taken = 1'b0;
    mem_rd = 5'd0; mem_rf_enable = 1'b0; wb_rd = 5'd0; wb_rf_enable = 1'b0;
  endtask

  task automatic set_load_use();
    ex_load_instr = 1'b1; ex_rf_enable = 1'b1; ex_rd = 5'd5;
    id_rs = 5'd5; id_use_rs = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    clear_inputs();
    reset = 1'b0;
    #3;
    chk("rst_state_b", {14'd0, ib.state}, 16'd0);
    chk("rst_cnt_b", ib.stall_count, 16'd0);
    chk("rst_cnt_a", ia.stall_count, 16'd0);

    // forwarding while in reset
    id_rt = 5'd7; id_use_rt = 1'b1;
    ex_rd = 5'd7; ex_rf_enable = 1'b1; ex_load_instr = 1'b0;
    mem_rd = 5'd7; mem_rf_enable = 1'b1; wb_rd = 5'd7; wb_rf_enable = 1'b1;
    #1 chk("fwd_b_ex", {14'd0, ia.fwd_b}, 16'h1);
    ex_rf_enable = 1'b0;
    #1 chk("fwd_b_mem", {14'd0, ia.fwd_b}, 16'h2);
    mem_rf_enable = 1'b0;
    #1 chk("fwd_b_wb", {14'd0, ia.fwd_b}, 16'h3);
    wb_rf_enable = 1'b0;
    #1 chk("fwd_b_rf", {14'd0, ia.fwd_b}, 16'h0);
    ex_rf_enable = 1'b1; mem_rf_enable = 1'b1; wb_rf_enable = 1'b1; id_rt = 5'd0;
    #1 chk("fwd_b_r0", {14'd0, ia.fwd_b}, 16'h0);
    id_rt = 5'd7; id_use_rt = 1'b0;
    #1 chk("fwd_b_unused", {14'd0, ia.fwd_b}, 16'h0);
    clear_inputs();
    id_rs = 5'd9; id_use_rs = 1'b1; ex_rd = 5'd9; ex_rf_enable = 1'b1; ex_load_instr = 1'b1;
    mem_rd = 5'd9; mem_rf_enable = 1'b1;
    #1 chk("fwd_a_load_skips_ex", {14'd0, ia.fwd_a}, 16'h2);
    chk("rst_pc_ld_with_lu", {15'd0, ia.pc_ld}, 16'h1);
    chk("rst_ex_nop_with_lu", {15'd0, ib.ex_nop}, 16'h0);

    clear_inputs();
    #1 reset = 1'b1;
    tick();

    // single-bubble load-use on dut_a, start of 3-bubble stall on dut_b
    set_load_use();
    #1;
    chk("a_lu_pc_ld", {15'd0, ia.pc_ld}, 16'h0);
    chk("a_lu_ifid_ld", {15'd0, ia.ifid_ld}, 16'h0);
    chk("a_lu_ex_nop", {15'd0, ia.ex_nop}, 16'h1);
    chk("b_lu_pc_ld", {15'd0, ib.pc_ld}, 16'h0);
    tick();
    clear_inputs();
    #1;
    chk("a_cnt_after_lu", ia.stall_count, 16'd1);
    chk("a_pc_ld_released", {15'd0, ia.pc_ld}, 16'h1);
    chk("b_state_stall1", {14'd0, ib.state}, 16'h1);
    chk("b_pc_ld_stall1", {15'd0, ib.pc_ld}, 16'h0);
    tick();
    chk("b_state_stall2", {14'd0, ib.state}, 16'h1);
    chk("b_pc_ld_stall2", {15'd0, ib.pc_ld}, 16'h0);
    tick();
    chk("b_state_run", {14'd0, ib.state}, 16'h0);
    chk("b_pc_ld_run", {15'd0, ib.pc_ld}, 16'h1);
    chk("b_cnt_3", ib.stall_count, 16'd3);
    chk("a_cnt_still_1", ia.stall_count, 16'd1);

    // branch together with load-use: branch wins; held through FLUSH to show it is ignored
    set_load_use();
    ex_branch_taken = 1'b1;
    #1;
    chk("b_br_flush", {15'd0, ib.ifid_flush}, 16'h1);
    chk("b_br_pc_ld", {15'd0, ib.pc_ld}, 16'h1);
    chk("b_br_ex_nop", {15'd0, ib.ex_nop}, 16'h1);
    chk("a_br_flush", {15'd0, ia.ifid_flush}, 16'h1);
    tick();
    chk("b_state_flush", {14'd0, ib.state}, 16'h2);
    chk("b_flush2", {15'd0, ib.ifid_flush}, 16'h1);
    chk("b_flush2_pc_ld", {15'd0, ib.pc_ld}, 16'h1);
    tick();
    clear_inputs();
    #1;
    chk("b_state_after_flush", {14'd0, ib.state}, 16'h0);
    chk("b_flush_done", {15'd0, ib.ifid_flush}, 16'h0);
    chk("b_cnt_unchanged", ib.stall_count, 16'd3);
    chk("a_cnt_unchanged", ia.stall_count, 16'd1);

    // reset pulsed during second STALL cycle of dut_b
    set_load_use();
    tick();
    clear_inputs();
    tick();
    chk("b_in_stall2", {14'd0, ib.state}, 16'h1);
    chk("b_cnt_5", ib.stall_count, 16'd5);
    #1 reset = 1'b0;
    #1;
    chk("b_async_state", {14'd0, ib.state}, 16'h0);
    chk("b_async_cnt", ib.stall_count, 16'd0);
    chk("b_async_pc_ld", {15'd0, ib.pc_ld}, 16'h1);
    #1 reset = 1'b1;
    tick();
    chk("b_no_residual_state", {14'd0, ib.state}, 16'h0);
    chk("b_no_residual_pc_ld", {15'd0, ib.pc_ld}, 16'h1);
    chk("b_no_residual_cnt", ib.stall_count, 16'd0);

    // continuous hazard: counter saturates
    set_load_use();
    for (int i = 0; i < 70000; i++) @(posedge clk);
    #1;
    chk("a_sat", ia.stall_count, 16'hFFFF);
    chk("b_sat", ib.stall_count, 16'hFFFF);
    tick();
    chk("a_sat_hold", ia.stall_count, 16'hFFFF);
    clear_inputs();

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ex_hazard_ctrl.md
EX_HAZARD_CTRL -- requirements
Module: ex_hazard_ctrl

Interface
REQ-001 Parameter LOAD_BUBBLES, default 1, range 1-3: bubble cycles inserted per load-use hazard.
REQ-002 Parameter BR_BUBBLES, default 1, range 1-3: flush cycles inserted per taken branch.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 id_rs, id_rt  input  5 each  source registers of the instruction in ID.
REQ-006 id_use_rs, id_use_rt  input  1 each  the ID instruction actually reads rs / rt.
REQ-007 ex_rd  input  5;  ex_rf_enable, ex_load_instr, ex_branch_taken  input  1 each  EX-stage destination, write enable, load flag, resolved taken branch.
REQ-008 mem_rd  input  5;  mem_rf_enable  input  1  MEM-stage destination and write enable.
REQ-009 wb_rd  input  5;  wb_rf_enable  input  1  WB-stage destination and write enable.
REQ-010 pc_ld, ifid_ld  output  1 each  PC / IF-ID register load enables (0 = hold).
REQ-011 ifid_flush  output  1  clears the IF-ID register to a NOP on the next edge.
REQ-012 ex_nop  output  1  forces the 18-bit control bundle entering EX to all zeros.
REQ-013 fwd_a, fwd_b  output  2 each  operand source select for rs / rt: 00 RF, 01 EX, 10 MEM, 11 WB.
REQ-014 state  output  2  current FSM state (RUN=00, STALL=01, FLUSH=10).
REQ-015 stall_count  output  16  saturating count of cycles with pc_ld=0.

Function
REQ-016 FSM states RUN, STALL, FLUSH; encoding 11 unreachable and SHALL return to RUN on the next edge.
REQ-017 Load-use hazard (lu) = ex_load_instr & ex_rf_enable & ex_rd!=0 & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
REQ-018 RUN, ex_branch_taken=1: ifid_flush=1, ex_nop=1, pc_ld=1, ifid_ld=1 in the same cycle; cnt<=BR_BUBBLES-1; next state FLUSH if BR_BUBBLES>1, else RUN.
REQ-019 RUN, lu=1, no branch: pc_ld=0, ifid_ld=0, ex_nop=1 in the same cycle; cnt<=LOAD_BUBBLES-1; next state STALL if LOAD_BUBBLES>1, else RUN.
REQ-020 Branch and lu in the same cycle: branch wins; lu ignored (the dependent instruction is flushed).
REQ-021 RUN, neither event: pc_ld=1, ifid_ld=1, ifid_flush=0, ex_nop=0.
REQ-022 STALL: pc_ld=0, ifid_ld=0, ex_nop=1, ifid_flush=0; cnt decrements each cycle; return to RUN on the edge where cnt==1.
REQ-023 FLUSH: pc_ld=1, ifid_ld=1, ifid_flush=1, ex_nop=1; cnt decrements; return to RUN on the edge where cnt==1.
REQ-024 ex_branch_taken and lu SHALL be ignored in STALL and FLUSH (EX holds a bubble).
REQ-025 Forwarding (combinational, per operand, operand not used -> 00): ex_rf_enable & !ex_load_instr & ex_rd==src -> 01; else mem_rf_enable & mem_rd==src -> 10; else wb_rf_enable & wb_rd==src -> 11; else 00.
REQ-026 Register 0 never forwards: src==0 -> 00 regardless of matches.
REQ-027 Forwarding priority is EX > MEM > WB when multiple stages match.
REQ-028 pc_ld, ifid_ld, ifid_flush, ex_nop SHALL be combinational from state and current inputs (zero-cycle latency); state, cnt, and stall_count SHALL be registered.
REQ-029 stall_count increments on every edge where pc_ld==0, saturates at 16'hFFFF, and never wraps.

Reset
REQ-030 While reset==0: state=RUN, cnt=0, stall_count=0; pc_ld=1, ifid_ld=1, ifid_flush=0, ex_nop=0; fwd_a/fwd_b follow REQ-025 from the inputs.
REQ-031 Reset asserted mid-STALL or mid-FLUSH SHALL abort the sequence immediately; after release, the FSM starts in RUN with no residual bubbles.

Verification
REQ-032 LOAD_BUBBLES=1, ex_load_instr=1, ex_rf_enable=1, ex_rd=5, id_rs=5, id_use_rs=1 -> pc_ld=0, ifid_ld=0, ex_nop=1 for that cycle only; stall_count 0->1.
REQ-033 LOAD_BUBBLES=3, same hazard for one cycle -> pc_ld=0 for exactly 3 consecutive cycles; state RUN->STALL->STALL->RUN; stall_count=3.
REQ-034 BR_BUBBLES=2, ex_branch_taken=1 together with a load-use hazard -> ifid_flush=1 for 2 cycles, pc_ld stays 1, stall_count unchanged.
REQ-035 id_rt=7, ex_rd=7 (ALU, rf_enable), mem_rd=7, wb_rd=7 -> fwd_b=01; with ex_rf_enable=0 -> 10; with id_rt=0 -> 00.
REQ-036 LOAD_BUBBLES=3, reset pulsed low during the 2nd STALL cycle -> state=RUN, stall_count=0, pc_ld=1 immediately (asynchronously).
REQ-037 Continuous load-use hazard held for 70000 cycles -> stall_count saturates at 65535 and holds.
